// File: rtl/mfp_ahb_ram_slave_ws.sv
// AHB-Lite RAM slave: byte-lane writes, read wait states, misalignment ERROR, write-to-read forwarding.
// Writes and zero-wait reads complete in one data phase; reads stall WAIT_STATES cycles via HREADYOUT.
module mfp_ahb_ram_slave_ws #(
  parameter int ADDR_WIDTH      = 10,
  parameter int WAIT_STATES     = 0,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  input  logic        SI_Endian,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_ERR1, S_ERR2} state_t;

  state_t                  r_state;
  logic [2:0]              r_cnt;
  logic                    r_hreadyout;
  logic                    r_hresp;
  logic [31:0]             r_rdata;
  logic                    r_wpend;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [3:0]              r_wmask;
  logic [31:0]             r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                    w_acc;
  logic                    w_mis;
  logic [3:0]              w_lane_le;
  logic [3:0]              w_lane;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_old;
  logic [31:0]             w_merged;
  logic                    w_unused;

  assign w_unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
  assign w_idx    = HADDR[ADDR_WIDTH+1:2];

  // ERR1 and RWAIT drive HREADYOUT low, so only IDLE/ERR2 may take a new address phase.
  assign w_acc = HSEL & HTRANS[1] & HREADY & ((r_state == S_IDLE) | (r_state == S_ERR2));

  always_comb begin
    w_mis = 1'b0;
    if (ERR_ON_MISALIGN) begin
      w_mis = (HSIZE > 3'd2) ||
              ((HSIZE == 3'd1) && HADDR[0]) ||
              ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    end
  end

  always_comb begin
    w_lane_le = 4'b1111;
    case (HSIZE)
      3'd0:    w_lane_le = 4'b0001 << HADDR[1:0];
      3'd1:    w_lane_le = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_lane_le = 4'b1111;
    endcase
    // Big-endian maps lane n to lane 3-n, which is a bit reversal of the mask.
    w_lane = SI_Endian ? {w_lane_le[0], w_lane_le[1], w_lane_le[2], w_lane_le[3]} : w_lane_le;
  end

  always_comb begin
    w_old    = r_mem[r_waddr];
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (r_wmask[i]) w_merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && r_wpend) r_mem[r_waddr] <= w_merged;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_rdata     <= 32'd0;
      r_wpend     <= 1'b0;
      r_waddr     <= '0;
      r_wmask     <= 4'd0;
    end else begin
      r_wpend <= 1'b0;
      if (w_acc && HWRITE && !w_mis) begin
        r_wpend <= 1'b1;
        r_waddr <= w_idx;
        r_wmask <= w_lane;
      end
      // A write committing on this edge to the same word must be visible to the read.
      if (w_acc && !HWRITE && !w_mis) begin
        r_rdata <= (r_wpend && (r_waddr == w_idx)) ? w_merged : r_mem[w_idx];
      end

      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_acc && w_mis) begin
            r_state     <= S_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (w_acc && !HWRITE && (WAIT_STATES > 0)) begin
            r_state     <= S_RWAIT;
            r_cnt       <= 3'(WAIT_STATES);
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
        S_RWAIT: begin
          if (r_cnt <= 3'd1) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign HRDATA    = r_rdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_mfp_ahb_ram_slave_ws.sv
// Directed bench for the AHB RAM slave: a zero-wait instance and a three-wait-state instance share the bus.
module tb_mfp_ahb_ram_slave_ws;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, sel, use3, hwrite, si_endian;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hsel0, hsel3, hready;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;
  int          total = 0;
  int          bad = 0;

  assign hsel0  = sel & ~use3;
  assign hsel3  = sel & use3;
  assign hready = use3 ? rdy3 : rdy0;

  mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(10), .WAIT_STATES(0), .ERR_ON_MISALIGN(1'b1)) u_ws0 (
    .HCLK(clk), .HRESET(hreset), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans),
    .HWRITE(hwrite), .HSEL(hsel0), .HREADY(hready), .HWDATA(hwdata), .SI_Endian(si_endian),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(10), .WAIT_STATES(3), .ERR_ON_MISALIGN(1'b1)) u_ws3 (
    .HCLK(clk), .HRESET(hreset), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans),
    .HWRITE(hwrite), .HSEL(hsel3), .HREADY(hready), .HWDATA(hwdata), .SI_Endian(si_endian),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    sel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = a;
  endtask

  task automatic set_idle();
    sel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    set_addr(1'b1, sz, a);
    tick();
    hwdata = d;
    set_idle();
    tick();
  endtask

  // Leaves the bench in the read data-phase cycle of the zero-wait instance.
  task automatic do_read0(input logic [31:0] a);
    set_addr(1'b0, 3'd2, a);
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    set_idle();
    tick();
    tick();
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_rdy0 got=%b want=1", rdy0); end
    total++; if (resp0 !== 1'b0) begin bad++; $display("FAIL rst_resp0 got=%b want=0", resp0); end
    total++; if (rdata0 !== 32'd0) begin bad++; $display("FAIL rst_rdata0 got=%h want=0", rdata0); end
    total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL rst_rdy3 got=%b want=1", rdy3); end
    total++; if (resp3 !== 1'b0) begin bad++; $display("FAIL rst_resp3 got=%b want=0", resp3); end
    total++; if (rdata3 !== 32'd0) begin bad++; $display("FAIL rst_rdata3 got=%h want=0", rdata3); end
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_word_rw();
    use3 = 1'b0; si_endian = 1'b0;
    do_write(32'h10, 3'd2, 32'hDEADBEEF);
    do_read0(32'h10);
    total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd got=%h want=deadbeef", rdata0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL word_rdy got=%b want=1", rdy0); end
    total++; if (resp0 !== 1'b0) begin bad++; $display("FAIL word_resp got=%b want=0", resp0); end
  endtask

  task automatic test_byte_lanes();
    si_endian = 1'b0;
    do_write(32'h10, 3'd2, 32'h0);
    do_write(32'h11, 3'd0, 32'hAAAAAAAA);
    do_read0(32'h10);
    total++; if (rdata0 !== 32'h0000AA00) begin bad++; $display("FAIL byte_le got=%h want=0000aa00", rdata0); end
    do_write(32'h10, 3'd2, 32'h0);
    do_write(32'h12, 3'd1, 32'hBBBBBBBB);
    do_read0(32'h10);
    total++; if (rdata0 !== 32'hBBBB0000) begin bad++; $display("FAIL half_le got=%h want=bbbb0000", rdata0); end
    si_endian = 1'b1;
    do_write(32'h10, 3'd2, 32'h0);
    do_write(32'h11, 3'd0, 32'hAAAAAAAA);
    do_read0(32'h10);
    total++; if (rdata0 !== 32'h00AA0000) begin bad++; $display("FAIL byte_be got=%h want=00aa0000", rdata0); end
    si_endian = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    use3 = 1'b1;
    do_write(32'h40, 3'd2, 32'hCAFEF00D);
    set_addr(1'b0, 3'd2, 32'h40);
    tick();
    set_idle();
    for (int i = 1; i <= 3; i++) begin
      total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL ws_stall%0d got=%b want=0", i, rdy3); end
      tick();
    end
    total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL ws_done_rdy got=%b want=1", rdy3); end
    total++; if (rdata3 !== 32'hCAFEF00D) begin bad++; $display("FAIL ws_data got=%h want=cafef00d", rdata3); end
    total++; if (resp3 !== 1'b0) begin bad++; $display("FAIL ws_resp got=%b want=0", resp3); end
    tick();
    use3 = 1'b0;
  endtask

  task automatic test_misalign();
    use3 = 1'b0;
    do_write(32'h00, 3'd2, 32'h11223344);
    set_addr(1'b1, 3'd1, 32'h03);
    tick();
    hwdata = 32'hFFFFFFFF;
    set_idle();
    total++; if ({rdy0, resp0} !== 2'b01) begin bad++; $display("FAIL err1 got rdy/resp=%b%b want=01", rdy0, resp0); end
    tick();
    total++; if ({rdy0, resp0} !== 2'b11) begin bad++; $display("FAIL err2 got rdy/resp=%b%b want=11", rdy0, resp0); end
    tick();
    total++; if ({rdy0, resp0} !== 2'b10) begin bad++; $display("FAIL err_end got rdy/resp=%b%b want=10", rdy0, resp0); end
    do_read0(32'h00);
    total++; if (rdata0 !== 32'h11223344) begin bad++; $display("FAIL err_nowrite got=%h want=11223344", rdata0); end
    set_addr(1'b0, 3'd3, 32'h00);
    tick();
    set_idle();
    total++; if ({rdy0, resp0} !== 2'b01) begin bad++; $display("FAIL oversize got rdy/resp=%b%b want=01", rdy0, resp0); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    use3 = 1'b0; si_endian = 1'b0;
    set_addr(1'b1, 3'd2, 32'h20);
    tick();
    hwdata = 32'h12345678;
    set_addr(1'b0, 3'd2, 32'h20);
    tick();
    total++; if (rdata0 !== 32'h12345678) begin bad++; $display("FAIL fwd_word got=%h want=12345678", rdata0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL fwd_rdy got=%b want=1", rdy0); end
    set_addr(1'b1, 3'd0, 32'h23);
    tick();
    hwdata = 32'hAAAAAAAA;
    set_addr(1'b0, 3'd2, 32'h20);
    tick();
    total++; if (rdata0 !== 32'hAA345678) begin bad++; $display("FAIL fwd_byte got=%h want=aa345678", rdata0); end
    set_addr(1'b0, 3'd2, 32'h10);
    tick();
    set_addr(1'b0, 3'd2, 32'h20);
    total++; if (rdata0 !== 32'h00AA0000) begin bad++; $display("FAIL b2b_rd1 got=%h want=00aa0000", rdata0); end
    tick();
    set_idle();
    total++; if (rdata0 !== 32'hAA345678 || rdy0 !== 1'b1) begin
      bad++; $display("FAIL b2b_rd2 got=%h rdy=%b want=aa345678 rdy=1", rdata0, rdy0);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int n;
    use3 = 1'b1;
    set_addr(1'b0, 3'd2, 32'h40);
    tick();
    set_idle();
    tick();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    total++; if ({rdy3, resp3} !== 2'b10) begin bad++; $display("FAIL rwait_rst got rdy/resp=%b%b want=10", rdy3, resp3); end
    total++; if (rdata3 !== 32'd0) begin bad++; $display("FAIL rwait_rst_data got=%h want=0", rdata3); end
    set_addr(1'b0, 3'd2, 32'h40);
    tick();
    set_idle();
    n = 0;
    while (rdy3 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++; if (n !== 3) begin bad++; $display("FAIL post_rst_wait got=%0d want=3", n); end
    total++; if (rdata3 !== 32'hCAFEF00D) begin bad++; $display("FAIL post_rst_data got=%h want=cafef00d", rdata3); end
    tick();
    use3 = 1'b0;
    do_write(32'h30, 3'd2, 32'h55555555);
    set_addr(1'b1, 3'd2, 32'h30);
    tick();
    hwdata = 32'h99999999;
    set_idle();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    do_read0(32'h30);
    total++; if (rdata0 !== 32'h55555555) begin bad++; $display("FAIL pend_discard got=%h want=55555555", rdata0); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; use3 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    haddr = 32'd0; hwdata = 32'd0; si_endian = 1'b0; hreset = 1'b1;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
